// File: rtl/channel_burst_arbiter.sv
// Round-robin arbiter merging M requester channels onto one sink, granting bursts of up to
// MaxBurst words or one packet (EopBit). Define CHANNEL_BURST_ARBITER_STATS_EN for transfer counters.
module channel_burst_arbiter #(
  parameter int N        = 32,
  parameter int M        = 4,
  parameter int MaxBurst = 4,
  parameter int EopBit   = -1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [M-1:0]         in_v,
  input  logic [M-1:0][N-1:0]  in_d,
  output logic [M-1:0]         in_a,
  output logic                 out_v,
  output logic [N-1:0]         out_d,
  input  logic                 out_a,
  output logic                 grant_v,
  output logic [$clog2(M)-1:0] grant_id
`ifdef CHANNEL_BURST_ARBITER_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [M-1:0][15:0]   stats_count
`endif
);
  localparam int IW = $clog2(M);
  localparam int BW = $clog2(MaxBurst + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(M - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MaxBurst - 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [IW-1:0] owner_r, owner_nxt_s;
  logic [IW-1:0] ptr_r, ptr_nxt_s;
  logic [BW-1:0] beats_r, beats_nxt_s;
  logic [IW-1:0] sel_s, cur_s;
  logic          eop_s, xfer_s;
  int            off_s, best_s;

  generate
    if (EopBit >= 0) begin : g_eop
      assign eop_s = out_d[EopBit];
    end else begin : g_no_eop
      assign eop_s = 1'b0;
    end
  endgenerate

  // Round-robin pick: the valid input at the smallest cyclic distance after ptr_r.
  always_comb begin
    sel_s  = ptr_r;
    best_s = M;
    off_s  = 0;
    for (int j = 0; j < M; j++) begin
      off_s = (j + M - 1 - int'(ptr_r)) % M;
      if (in_v[j] && (off_s < best_s)) begin
        best_s = off_s;
        sel_s  = IW'(j);
      end else begin
        best_s = best_s;
      end
    end
  end

  // Datapath: route the current source to out and out_a back to that source only.
  always_comb begin
    out_v = 1'b0;
    in_a  = {M{1'b0}};
    cur_s = (state_r == LOCKED) ? owner_r : sel_s;
    if (reset) begin
      out_v = 1'b0;
    end else if (state_r == LOCKED) begin
      out_v = in_v[owner_r];
    end else begin
      out_v = |in_v;
    end
    out_d = in_d[cur_s];
    if (out_v) begin
      in_a[cur_s] = out_a;
    end else begin
      in_a = {M{1'b0}};
    end
  end

  assign xfer_s   = out_v & out_a;
  assign grant_v  = (state_r == LOCKED);
  assign grant_id = grant_v ? owner_r : {IW{1'b0}};

  // Next-state logic: open a lock on a non-final word, close it on burst limit, EOP or dropped valid.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    ptr_nxt_s   = ptr_r;
    beats_nxt_s = beats_r;
    case (state_r)
      IDLE: begin
        if (xfer_s && ((MaxBurst == 1) || eop_s)) begin
          ptr_nxt_s = sel_s;
        end else if (xfer_s) begin
          state_nxt_s = LOCKED;
          owner_nxt_s = sel_s;
          beats_nxt_s = BW'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED: begin
        if (!in_v[owner_r]) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = owner_r;
        end else if (xfer_s && ((beats_r == BURST_LAST) || eop_s)) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = owner_r;
          beats_nxt_s = beats_r + BW'(1);
        end else if (xfer_s) begin
          beats_nxt_s = beats_r + BW'(1);
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbitration state registers; ptr starts at M-1 so input 0 has first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      owner_r <= {IW{1'b0}};
      ptr_r   <= LAST_IDX;
      beats_r <= {BW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      ptr_r   <= ptr_nxt_s;
      beats_r <= beats_nxt_s;
    end
  end

`ifdef CHANNEL_BURST_ARBITER_STATS_EN
  // Per-input saturating transfer counters; a clear wins over a same-cycle transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stats_count <= {M{16'h0000}};
    end else begin
      for (int i = 0; i < M; i++) begin
        if (stats_clr) begin
          stats_count[i] <= 16'h0000;
        end else if (in_a[i] && (stats_count[i] != 16'hFFFF)) begin
          stats_count[i] <= stats_count[i] + 16'h0001;
        end else begin
          stats_count[i] <= stats_count[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_channel_burst_arbiter.sv
// Self-checking bench for channel_burst_arbiter (M=4, MaxBurst=4, EOP on bit 31): directed
// scenarios plus a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_channel_burst_arbiter;
  localparam int N    = 32;
  localparam int M    = 4;
  localparam int MB   = 4;
  localparam int EOPB = N - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [M-1:0]        in_v = '0;
  logic [M-1:0][N-1:0] in_d = '0;
  logic [M-1:0]        in_a;
  logic                out_v;
  logic [N-1:0]        out_d;
  logic                out_a = 1'b0;
  logic                grant_v;
  logic [1:0]          grant_id;
`ifdef CHANNEL_BURST_ARBITER_STATS_EN
  logic                stats_clr = 1'b0;
  logic [M-1:0][15:0]  stats_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [M-1:0] hold = '0;
  logic [N-1:0] src_q [M][$];
  logic [N-1:0] exp_q [M][$];

  channel_burst_arbiter #(.N(N), .M(M), .MaxBurst(MB), .EopBit(EOPB)) dut (
    .clk(clk), .reset(reset), .in_v(in_v), .in_d(in_d), .in_a(in_a),
    .out_v(out_v), .out_d(out_d), .out_a(out_a), .grant_v(grant_v), .grant_id(grant_id)
`ifdef CHANNEL_BURST_ARBITER_STATS_EN
    , .stats_clr(stats_clr), .stats_count(stats_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] mk(input int src, input int seq, input bit eop);
    logic [3:0]  s4;
    logic [23:0] q24;
    s4  = src[3:0];
    q24 = seq[23:0];
    return {eop, 3'b000, s4, q24};
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < M; i++) begin
      in_v[i] = (src_q[i].size() > 0) && !hold[i];
      in_d[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic step();
    logic [M-1:0] xf;
    xf = in_v & in_a;
    @(posedge clk);
    #1;
    for (int i = 0; i < M; i++) if (xf[i]) void'(src_q[i].pop_front());
    apply_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_a = 1'b0;
    hold  = '0;
    for (int i = 0; i < M; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    apply_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_a = 1'b1;
    hold  = '0;
    for (int i = 0; i < M; i++) begin
      src_q[i].delete();
      src_q[i].push_back(mk(i, 0, 1'b0));
    end
    apply_inputs();
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (out_v !== 1'b0) begin failures++; $display("FAIL reset_out_v got=%b exp=0", out_v); end
    checks++; if (in_a !== 4'b0000) begin failures++; $display("FAIL reset_in_a got=%b exp=0000", in_a); end
    checks++; if (grant_v !== 1'b0 || grant_id !== 2'd0) begin
      failures++; $display("FAIL reset_grant got=%b/%0d exp=0/0", grant_v, grant_id);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (out_v !== 1'b1 || out_d !== mk(0, 0, 1'b0) || in_a !== 4'b0001) begin
      failures++; $display("FAIL reset_first_grant got v=%b d=%h a=%b exp v=1 d=%h a=0001", out_v, out_d, in_a, mk(0, 0, 1'b0));
    end
  endtask

  task automatic test_fairness();
    int src, seq;
    do_reset();
    for (int i = 0; i < M; i++) for (int s = 0; s < 8; s++) src_q[i].push_back(mk(i, s, 1'b0));
    out_a = 1'b1;
    apply_inputs();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      src = (c / 4) % 4;
      seq = (c / 16) * 4 + c % 4;
      checks++; if (out_v !== 1'b1 || out_d !== mk(src, seq, 1'b0)) begin
        failures++; $display("FAIL fair_data cyc=%0d got v=%b d=%h exp d=%h", c, out_v, out_d, mk(src, seq, 1'b0));
      end
      checks++; if (grant_v !== ((c % 4) != 0)) begin
        failures++; $display("FAIL fair_grant_v cyc=%0d got=%b exp=%b", c, grant_v, ((c % 4) != 0));
      end
      if ((c % 4) != 0) begin
        checks++; if (grant_id !== 2'(src)) begin
          failures++; $display("FAIL fair_grant_id cyc=%0d got=%0d exp=%0d", c, grant_id, src);
        end
      end
      step();
    end
  endtask

  task automatic test_eop_packet();
    int src, seq;
    bit eop;
    do_reset();
    out_a = 1'b1;
    for (int s = 0; s < 3; s++) src_q[2].push_back(mk(2, s, s == 2));
    apply_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      src = (c < 3) ? 2 : 1;
      seq = (c < 3) ? c : 0;
      eop = (c == 2);
      checks++; if (out_v !== 1'b1 || out_d !== mk(src, seq, eop)) begin
        failures++; $display("FAIL eop_data cyc=%0d got=%h exp=%h", c, out_d, mk(src, seq, eop));
      end
      checks++; if (in_a !== (4'b0001 << src) || grant_v !== (c == 1 || c == 2)) begin
        failures++; $display("FAIL eop_grant cyc=%0d got a=%b gv=%b exp a=%b", c, in_a, grant_v, (4'b0001 << src));
      end
      step();
      if (c == 0) begin
        src_q[1].push_back(mk(1, 0, 1'b0));
        src_q[1].push_back(mk(1, 1, 1'b0));
        apply_inputs();
      end
    end
    // EOP coinciding with the burst limit must close exactly one lock.
    do_reset();
    out_a = 1'b1;
    for (int s = 0; s < 4; s++) src_q[0].push_back(mk(0, s, s == 3));
    for (int s = 0; s < 8; s++) src_q[1].push_back(mk(1, s, 1'b0));
    apply_inputs();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      src = (c < 4) ? 0 : 1;
      checks++; if (out_d !== mk(src, c % 4, c == 3) || grant_v !== ((c % 4) != 0)) begin
        failures++; $display("FAIL eop_maxburst cyc=%0d got d=%h gv=%b exp d=%h gv=%b", c, out_d, grant_v, mk(src, c % 4, c == 3), ((c % 4) != 0));
      end
      step();
    end
  endtask

  task automatic test_abandon();
    do_reset();
    out_a = 1'b1;
    for (int s = 0; s < 5; s++) src_q[1].push_back(mk(1, s, 1'b0));
    for (int s = 0; s < 3; s++) src_q[3].push_back(mk(3, s, 1'b0));
    apply_inputs();
    @(negedge clk);
    checks++; if (out_d !== mk(1, 0, 1'b0) || grant_v !== 1'b0) begin
      failures++; $display("FAIL abandon_first got d=%h gv=%b exp d=%h gv=0", out_d, grant_v, mk(1, 0, 1'b0));
    end
    step();
    @(negedge clk);
    checks++; if (out_d !== mk(1, 1, 1'b0) || grant_v !== 1'b1 || grant_id !== 2'd1) begin
      failures++; $display("FAIL abandon_locked got d=%h gv=%b id=%0d exp d=%h gv=1 id=1", out_d, grant_v, grant_id, mk(1, 1, 1'b0));
    end
    step();
    hold[1] = 1'b1;
    src_q[0].push_back(mk(0, 0, 1'b0));
    src_q[0].push_back(mk(0, 1, 1'b0));
    apply_inputs();
    @(negedge clk);
    checks++; if (out_v !== 1'b0 || in_a !== 4'b0000 || grant_v !== 1'b1) begin
      failures++; $display("FAIL abandon_gap got v=%b a=%b gv=%b exp v=0 a=0000 gv=1", out_v, in_a, grant_v);
    end
    step();
    @(negedge clk);
    checks++; if (out_v !== 1'b1 || out_d !== mk(3, 0, 1'b0) || in_a !== 4'b1000 || grant_v !== 1'b0) begin
      failures++; $display("FAIL abandon_next got v=%b d=%h a=%b gv=%b exp d=%h a=1000 gv=0", out_v, out_d, in_a, grant_v, mk(3, 0, 1'b0));
    end
    step();
    @(negedge clk);
    checks++; if (out_d !== mk(3, 1, 1'b0) || grant_v !== 1'b1 || grant_id !== 2'd3) begin
      failures++; $display("FAIL abandon_relock got d=%h gv=%b id=%0d exp d=%h gv=1 id=3", out_d, grant_v, grant_id, mk(3, 1, 1'b0));
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    out_a = 1'b1;
    for (int s = 0; s < 6; s++) src_q[2].push_back(mk(2, s, 1'b0));
    apply_inputs();
    @(negedge clk);
    checks++; if (out_d !== mk(2, 0, 1'b0)) begin
      failures++; $display("FAIL midrst_start got=%h exp=%h", out_d, mk(2, 0, 1'b0));
    end
    step();
    reset = 1'b1;
    src_q[0].push_back(mk(0, 0, 1'b0));
    src_q[1].push_back(mk(1, 0, 1'b0));
    apply_inputs();
    @(negedge clk);
    checks++; if (out_v !== 1'b0 || in_a !== 4'b0000 || grant_v !== 1'b0) begin
      failures++; $display("FAIL midrst_during got v=%b a=%b gv=%b exp v=0 a=0000 gv=0", out_v, in_a, grant_v);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_d !== mk(0, 0, 1'b0) || in_a !== 4'b0001 || grant_v !== 1'b0) begin
      failures++; $display("FAIL midrst_after got d=%h a=%b gv=%b exp d=%h a=0001 gv=0", out_d, in_a, grant_v, mk(0, 0, 1'b0));
    end
  endtask

  task automatic test_random();
    int owner, beats, last, pick, j;
    bit ev, eop, done, empty;
    logic [M-1:0] ea;
    logic [N-1:0] w;
    do_reset();
    for (int i = 0; i < M; i++) begin
      for (int s = 0; s < 30; s++) begin
        w = mk(i, s, $urandom_range(0, 99) < 15);
        src_q[i].push_back(w);
        exp_q[i].push_back(w);
      end
    end
    owner = -1; beats = 0; last = M - 1; done = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc < 400) begin
        out_a = ($urandom_range(0, 99) < 30);
        for (int i = 0; i < M; i++) hold[i] = ($urandom_range(0, 99) < 25);
      end else begin
        out_a = 1'b1;
        hold  = '0;
      end
      apply_inputs();
      empty = 1'b1;
      for (int i = 0; i < M; i++) if (src_q[i].size() > 0) empty = 1'b0;
      if (cyc >= 400 && empty) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      if (owner < 0) begin
        pick = -1;
        for (int k = 1; k <= M; k++) begin
          j = (last + k) % M;
          if (pick < 0 && in_v[j[1:0]]) pick = j;
        end
        ev = (pick >= 0);
      end else begin
        pick = owner;
        ev = in_v[pick[1:0]];
      end
      ea = (ev && out_a) ? (4'b0001 << pick) : 4'b0000;
      checks++; if (out_v !== ev) begin failures++; $display("FAIL rand_out_v cyc=%0d got=%b exp=%b", cyc, out_v, ev); end
      checks++; if (in_a !== ea) begin failures++; $display("FAIL rand_in_a cyc=%0d got=%b exp=%b", cyc, in_a, ea); end
      checks++; if ((in_a & ~in_v) !== 4'b0000) begin failures++; $display("FAIL rand_a_without_v cyc=%0d a=%b v=%b", cyc, in_a, in_v); end
      checks++; if (grant_v !== (owner >= 0) || grant_id !== ((owner >= 0) ? 2'(owner) : 2'd0)) begin
        failures++; $display("FAIL rand_grant cyc=%0d got=%b/%0d exp owner=%0d", cyc, grant_v, grant_id, owner);
      end
      if (ev && out_a) begin
        checks++; if (exp_q[pick].size() == 0 || out_d !== exp_q[pick][0]) begin
          failures++; $display("FAIL rand_data cyc=%0d src=%0d got=%h", cyc, pick, out_d);
        end
        if (exp_q[pick].size() > 0) void'(exp_q[pick].pop_front());
      end
      eop = ev ? in_d[pick[1:0]][EOPB] : 1'b0;
      if (owner < 0) begin
        if (ev && out_a) begin
          if (MB == 1 || eop) last = pick;
          else begin owner = pick; beats = 1; end
        end
      end else if (!ev) begin
        last = owner; owner = -1;
      end else if (out_a) begin
        beats++;
        if (beats == MB || eop) begin last = owner; owner = -1; end
      end
      step();
    end
    checks++; if (!done) begin failures++; $display("FAIL rand_timeout drain did not complete within cycle budget"); end
    for (int i = 0; i < M; i++) begin
      checks++; if (exp_q[i].size() != 0) begin
        failures++; $display("FAIL rand_loss src=%0d undelivered=%0d exp=0", i, exp_q[i].size());
      end
    end
  endtask

`ifdef CHANNEL_BURST_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    stats_clr = 1'b0;
    out_a = 1'b1;
    in_v = 4'b0001;
    in_d[0] = mk(0, 0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    checks++; if (stats_count[0] !== 16'hFFFF || stats_count[1] !== 16'h0000) begin
      failures++; $display("FAIL stats_saturate got=%h/%h exp=ffff/0000", stats_count[0], stats_count[1]);
    end
    stats_clr = 1'b1;
    @(negedge clk);
    checks++; if (in_a[0] !== 1'b1) begin failures++; $display("FAIL stats_clr_xfer got a=%b exp=1", in_a[0]); end
    @(posedge clk);
    #1 stats_clr = 1'b0;
    checks++; if (stats_count[0] !== 16'h0000) begin failures++; $display("FAIL stats_clear got=%h exp=0000", stats_count[0]); end
    @(posedge clk);
    #1;
    checks++; if (stats_count[0] !== 16'h0001) begin failures++; $display("FAIL stats_count_after got=%h exp=0001", stats_count[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_eop_packet();
    test_abandon();
    test_reset_midburst();
    test_random();
`ifdef CHANNEL_BURST_ARBITER_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
